// File: rtl/platform_pio_input_capture.sv
// Avalon-MM input PIO: synchronizes in_port, latches edges into a sticky W1C register, drives a maskable level irq.
// Optional per-bit debounce is built in when PIO_DEBOUNCE_EN is defined.
module platform_pio_input_capture #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

`ifdef PIO_DEBOUNCE_EN
    localparam int unsigned         PRIME_W    = 17;
    localparam logic [PRIME_W-1:0]  PRIME_DONE = PRIME_W'(3 + DEBOUNCE_CYCLES);
`else
    localparam int unsigned         PRIME_W    = 2;
    localparam logic [PRIME_W-1:0]  PRIME_DONE = PRIME_W'(3);
`endif

    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   r_prev;
    logic [WIDTH-1:0]   r_cap;
    logic [WIDTH-1:0]   r_mask;
    logic [PRIME_W-1:0] r_prime;

    logic [WIDTH-1:0]   w_stable;
    logic [WIDTH-1:0]   w_rise;
    logic [WIDTH-1:0]   w_fall;
    logic [WIDTH-1:0]   w_ev;
    logic [WIDTH-1:0]   w_clr;
    logic               w_wr;
    logic               w_primed;
    logic               w_unused_wd;

    // Upper writedata bits beyond WIDTH carry no meaning.
    assign w_unused_wd = ^writedata;

    // Two-flop synchronizer for the asynchronous inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0]      r_db_cnt [WIDTH];
    logic [WIDTH-1:0] r_stable;

    // A bit is accepted only after it has differed from stable for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (r_sync2[i] != r_stable[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_stable[i] <= r_sync2[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_stable = r_stable;
`else
    assign w_stable = r_sync2;
`endif

    // Priming holds edge detection off until the pipeline has filled after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prime <= '0;
        end else if (r_prime != PRIME_DONE) begin
            r_prime <= r_prime + PRIME_W'(1);
        end
    end

    assign w_primed = (r_prime == PRIME_DONE);

    always_comb begin
        w_rise = w_stable & ~r_prev;
        w_fall = ~w_stable & r_prev;
        case (EDGE_TYPE)
            32'd0:   w_ev = w_rise;
            32'd1:   w_ev = w_fall;
            default: w_ev = w_rise | w_fall;
        endcase
        if (!w_primed) begin
            w_ev = '0;
        end
    end

    assign w_wr  = chipselect & ~write_n;
    assign w_clr = (w_wr && (address == ADDR_CAP)) ? writedata[WIDTH-1:0] : '0;

    // Edge history, sticky capture (new event beats a same-cycle clear) and mask
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= '0;
            r_cap  <= '0;
            r_mask <= '0;
        end else begin
            r_prev <= w_stable;
            r_cap  <= (r_cap & ~w_clr) | w_ev;
            if (w_wr && (address == ADDR_MASK)) begin
                r_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata = 32'(w_stable);
            ADDR_MASK: readdata = 32'(r_mask);
            ADDR_CAP:  readdata = 32'(r_cap);
            default:   readdata = '0;
        endcase
    end

    assign irq = |(r_cap & r_mask);

endmodule

// File: tb/tb_platform_pio_input_capture.sv
// Bench for platform_pio_input_capture (default build): a rising-edge and an any-edge instance share stimulus
// and are checked every cycle against an input-history reference model.
module tb_platform_pio_input_capture;
    localparam int unsigned W = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd0;
    logic [31:0]   rd2;
    logic          irq0;
    logic          irq2;

    int n_pass  = 0;
    int n_total = 0;

    always #10 clk = ~clk;

    platform_pio_input_capture #(.WIDTH(W), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0)
    );

    platform_pio_input_capture #(.WIDTH(W), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2)
    );

    // Reference state: in_port as seen at each clock edge since reset release, plus mask and captures.
    logic [W-1:0] hist [$];
    logic [W-1:0] m_mask;
    logic [W-1:0] m_cap [2];

    function automatic logic [W-1:0] h(input int k);
        if (k < 1 || k > hist.size()) return '0;
        return hist[k-1];
    endfunction

    // DATA after edge n shows the input from edge n-1; an edge evaluated at edge n compares
    // inputs from edges n-2 and n-3, and edges 1..3 after release never capture.
    task automatic model_edge();
        logic [W-1:0] st, pv, rise, fall, ev, clr;
        int n;
        hist.push_back(in_port);
        n    = hist.size();
        st   = h(n - 2);
        pv   = h(n - 3);
        rise = st & ~pv;
        fall = ~st & pv;
        clr  = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
        for (int i = 0; i < 2; i++) begin
            ev = (i == 0) ? rise : (rise | fall);
            if (n < 4) ev = '0;
            m_cap[i] = (m_cap[i] & ~clr) | ev;
        end
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        logic [1:0]  saved;
        logic [31:0] e0, e2;
        saved = address;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            case (a)
                0:       begin e0 = 32'(h(hist.size() - 1)); e2 = e0; end
                2:       begin e0 = 32'(m_mask); e2 = e0; end
                3:       begin e0 = 32'(m_cap[0]); e2 = 32'(m_cap[1]); end
                default: begin e0 = '0; e2 = '0; end
            endcase
            chk($sformatf("%s rise rd a%0d", tag, a), rd0, e0);
            chk($sformatf("%s any rd a%0d", tag, a), rd2, e2);
        end
        chk($sformatf("%s rise irq", tag), 32'(irq0), 32'(|(m_cap[0] & m_mask)));
        chk($sformatf("%s any irq", tag), 32'(irq2), 32'(|(m_cap[1] & m_mask)));
        address = saved;
    endtask

    task automatic step(input string tag);
        tick();
        check_all(tag);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        check_all("wr");
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] e0, input logic [31:0] e2);
        address = a;
        #1;
        chk({tag, " rise"}, rd0, e0);
        chk({tag, " any"}, rd2, e2);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '1;
        m_mask     = '0;
        m_cap      = '{default: '0};

        // Inputs held high through reset must not produce captures
        repeat (3) tick();
        check_all("in_reset");
        reset_n = 1'b1;
        repeat (10) step("prime");
        chk_rd("t1 data", 2'd0, 32'hF, 32'hF);
        chk_rd("t1 cap", 2'd3, 32'h0, 32'h0);
        chk("t1 irq", 32'(irq0), 32'h0);

        // Rising edge on bit1 with mask=2: DATA after 2 edges, capture and irq after 3
        in_port = '0;
        repeat (5) step("t2 idle");
        bus_write(2'd3, 32'hF);
        bus_write(2'd2, 32'h2);
        in_port = 4'h2;
        step("t2 e0");
        step("t2 e1");
        chk_rd("t2 data", 2'd0, 32'h2, 32'h2);
        chk_rd("t2 cap early", 2'd3, 32'h0, 32'h0);
        step("t2 e2");
        chk_rd("t2 cap", 2'd3, 32'h2, 32'h2);
        chk("t2 irq", 32'(irq0), 32'h1);

        // W1C clear, then a clear racing a fresh bit1 event
        bus_write(2'd3, 32'h2);
        chk_rd("t3 clr", 2'd3, 32'h0, 32'h0);
        chk("t3 irq clr", 32'(irq0), 32'h0);
        in_port = '0;
        repeat (4) step("t3 idle");
        bus_write(2'd3, 32'hF);
        in_port = 4'h2;
        step("t3 e0");
        step("t3 e1");
        bus_write(2'd3, 32'h2);
        chk_rd("t3 race", 2'd3, 32'h2, 32'h2);
        chk("t3 irq race", 32'(irq0), 32'h1);

        // Any-edge pulse on bit0 with mask off, then unmask and remask
        bus_write(2'd2, 32'h0);
        in_port = 4'h1;
        repeat (4) step("t4 idle");
        bus_write(2'd3, 32'hF);
        in_port = 4'h0;
        step("t4 lo");
        in_port = 4'h1;
        repeat (4) step("t4 hi");
        chk_rd("t4 cap", 2'd3, 32'h1, 32'h1);
        chk("t4 irq masked", 32'(irq2), 32'h0);
        bus_write(2'd2, 32'h1);
        chk("t4 irq unmask", 32'(irq2), 32'h1);
        bus_write(2'd2, 32'h0);
        chk("t4 irq remask", 32'(irq2), 32'h0);
        chk_rd("t4 cap kept", 2'd3, 32'h1, 32'h1);

        // Randomized traffic
        repeat (300) begin
            if ($urandom_range(2) == 0) in_port = W'($urandom);
            if ($urandom_range(3) == 0) begin
                bus_write(2'($urandom_range(3)), $urandom);
            end else begin
                address = 2'($urandom_range(3));
                step("rand");
            end
        end

        // Asynchronous reset with everything pending
        bus_write(2'd2, 32'hF);
        in_port = '0;
        repeat (4) step("t6 lo");
        in_port = '1;
        repeat (4) step("t6 hi");
        chk_rd("t6 pre cap", 2'd3, 32'hF, 32'hF);
        #2;
        reset_n = 1'b0;
        hist.delete();
        m_mask = '0;
        m_cap  = '{default: '0};
        chk_rd("t6 cap", 2'd3, 32'h0, 32'h0);
        chk_rd("t6 mask", 2'd2, 32'h0, 32'h0);
        chk("t6 irq rise", 32'(irq0), 32'h0);
        chk("t6 irq any", 32'(irq2), 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (8) step("t6 prime");
        chk_rd("t6 post cap", 2'd3, 32'h0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
